// File: rtl/pix_host_writer.sv
// pix_host_writer: byte-wide host command/data port feeding an RGB565 pixel FIFO,
// plus a free-running write address (page / row / column) for a panel controller.
//
// Host handshake: a byte is taken on every cycle with host_wr=1 (no back-pressure;
// host_busy is advisory). host_dc selects command (0) or data (1). The FIFO read
// side is show-ahead: FIFO_out is the head word whenever FIFO_full=1, and
// FIFO_RD_req=1 in such a cycle consumes it. A request with FIFO_full=0 is ignored.
//
// Optional build macro: PIX_LE_EN -- pixel bytes arrive low byte first.
module pix_host_writer #(
    parameter int H_ACT = 800,
    parameter int V_ACT = 480,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_wr,
    input  logic        host_dc,
    input  logic [7:0]  host_d,
    output logic        host_busy,
    output logic        ovf,
    output logic [15:0] FIFO_out,
    output logic        FIFO_full,
    input  logic        FIFO_RD_req,
    input  logic        startup_inc,
    output logic [8:0]  row_add_user,
    output logic [9:0]  col_add_user,
    output logic [2:0]  page_set,
    output logic [1:0]  fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PAGE_ARG = 2'd1,
        PIX_HI   = 2'd2,
        PIX_LO   = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      held;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            cmd_stb;
    logic            data_stb;
    logic            clr;
    logic            push;
    logic            pop;
    logic            full_i;
    logic            do_push;
    logic [15:0]     push_word;

    // Strobe decode and FIFO push/pop qualification
    always_comb begin
        cmd_stb  = host_wr & ~host_dc;
        data_stb = host_wr & host_dc;
        clr      = cmd_stb && (host_d == 8'h02);
        push     = data_stb && (state == PIX_LO);
        full_i   = (count == CW'(DEPTH));
        pop      = FIFO_RD_req && (count != '0);
        // A full FIFO still accepts a word when the head leaves in the same cycle
        do_push  = push && (!full_i || pop);
`ifdef PIX_LE_EN
        push_word = {host_d, held};
`else
        push_word = {held, host_d};
`endif
    end

    // Host byte FSM: commands win in every state and drop any half pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            held     <= 8'h00;
            page_set <= 3'd0;
        end else if (cmd_stb) begin
            held <= 8'h00;
            case (host_d)
                8'h01:   state <= PAGE_ARG;
                8'h2C:   state <= PIX_HI;
                default: state <= IDLE;
            endcase
        end else if (data_stb) begin
            case (state)
                PAGE_ARG: begin
                    page_set <= host_d[2:0];
                    state    <= IDLE;
                end
                PIX_HI: begin
                    held  <= host_d;
                    state <= PIX_LO;
                end
                PIX_LO:  state <= PIX_HI;
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while count is zero, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !pop)      count <= count + CW'(1);
            else if (!do_push && pop) count <= count - CW'(1);
            if (clr)                           ovf <= 1'b0;
            else if (push && full_i && !pop)   ovf <= 1'b1;
        end
    end

    // Raster write address: column steps per pulse, row steps on column wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_add_user <= 10'd0;
            row_add_user <= 9'd0;
        end else if (clr) begin
            col_add_user <= 10'd0;
            row_add_user <= 9'd0;
        end else if (startup_inc) begin
            if (col_add_user == 10'(H_ACT - 1)) begin
                col_add_user <= 10'd0;
                if (row_add_user == 9'(V_ACT - 1)) row_add_user <= 9'd0;
                else                               row_add_user <= row_add_user + 9'd1;
            end else begin
                col_add_user <= col_add_user + 10'd1;
            end
        end
    end

    assign FIFO_full = (count != '0);
    assign host_busy = full_i;
    assign FIFO_out  = (count != '0) ? mem[rd_ptr] : 16'h0000;
    assign fsm_state = state;

endmodule

// File: tb/tb_pix_host_writer.sv
// Bench for pix_host_writer: table of pixel byte pairs plus hand-written
// sequences for overflow, simultaneous push/pop, address wrap and reset.
module tb_pix_host_writer;

    localparam int H = 800;
    localparam int V = 6;   // short page so the full-page wrap stays quick
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        host_wr = 1'b0;
    logic        host_dc = 1'b0;
    logic [7:0]  host_d = 8'h00;
    logic        FIFO_RD_req = 1'b0;
    logic        startup_inc = 1'b0;
    logic        host_busy;
    logic        ovf;
    logic [15:0] FIFO_out;
    logic        FIFO_full;
    logic [8:0]  row_add_user;
    logic [9:0]  col_add_user;
    logic [2:0]  page_set;
    logic [1:0]  fsm_state;

    pix_host_writer #(.H_ACT(H), .V_ACT(V), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .host_wr(host_wr), .host_dc(host_dc), .host_d(host_d),
        .host_busy(host_busy), .ovf(ovf),
        .FIFO_out(FIFO_out), .FIFO_full(FIFO_full), .FIFO_RD_req(FIFO_RD_req),
        .startup_inc(startup_inc),
        .row_add_user(row_add_user), .col_add_user(col_add_user),
        .page_set(page_set), .fsm_state(fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Scoreboard and host-side model
    logic [15:0] exp_q[$];
    logic        exp_ovf = 1'b0;
    int          m_mode = 0;      // 0 idle, 1 page arg, 2 first byte, 3 second byte
    logic [7:0]  m_first = 8'h00;

    typedef struct {
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [15:0] be;
        logic [15:0] le;
    } vec_t;
    vec_t tbl[5];

    function automatic logic [15:0] pick(input logic [15:0] be, input logic [15:0] le);
`ifdef PIX_LE_EN
        return le;
`else
        return be;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic model_byte(input logic dc, input logic [7:0] d);
        logic [15:0] w;
        if (!dc) begin
            case (d)
                8'h01: m_mode = 1;
                8'h2C: m_mode = 2;
                8'h02: begin m_mode = 0; exp_ovf = 1'b0; end
                default: m_mode = 0;
            endcase
        end else if (m_mode == 1) begin
            m_mode = 0;
        end else if (m_mode == 2) begin
            m_first = d;
            m_mode = 3;
        end else if (m_mode == 3) begin
`ifdef PIX_LE_EN
            w = {d, m_first};
`else
            w = {m_first, d};
`endif
            if (exp_q.size() < D) exp_q.push_back(w);
            else exp_ovf = 1'b1;
            m_mode = 2;
        end
    endtask

    // Driver: one host byte, one cycle strobe
    task automatic send(input logic dc, input logic [7:0] d);
        @(negedge clk);
        host_wr = 1'b1; host_dc = dc; host_d = d;
        @(negedge clk);
        host_wr = 1'b0; host_dc = 1'b0;
        model_byte(dc, d);
    endtask

    // Driver: data byte together with a read of the current head
    task automatic send_with_pop(input logic [7:0] d);
        @(negedge clk);
        check("pop head", FIFO_out, exp_q[0]);
        host_wr = 1'b1; host_dc = 1'b1; host_d = d; FIFO_RD_req = 1'b1;
        @(negedge clk);
        host_wr = 1'b0; host_dc = 1'b0; FIFO_RD_req = 1'b0;
        void'(exp_q.pop_front());
        model_byte(1'b1, d);
    endtask

    // Driver: compare head with scoreboard, then consume it
    task automatic read_word(input string name);
        if (exp_q.size() == 0) begin
            check({name, " empty"}, FIFO_full, 1'b0);
        end else begin
            check({name, " valid"}, FIFO_full, 1'b1);
            check({name, " data"}, FIFO_out, exp_q[0]);
            FIFO_RD_req = 1'b1;
            @(negedge clk);
            FIFO_RD_req = 1'b0;
            void'(exp_q.pop_front());
        end
    endtask

    task automatic inc(input int n);
        @(negedge clk);
        startup_inc = 1'b1;
        repeat (n) @(negedge clk);
        startup_inc = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
        exp_ovf = 1'b0;
        m_mode = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        tbl[0] = '{8'hF8, 8'h1F, 16'hF81F, 16'h1FF8};
        tbl[1] = '{8'h00, 8'h00, 16'h0000, 16'h0000};
        tbl[2] = '{8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF};
        tbl[3] = '{8'h12, 8'h34, 16'h1234, 16'h3412};
        tbl[4] = '{8'h80, 8'h01, 16'h8001, 16'h0180};

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst FIFO_full", FIFO_full, 1'b0);
        check("rst host_busy", host_busy, 1'b0);
        check("rst ovf", ovf, 1'b0);
        check("rst FIFO_out", FIFO_out, 16'h0000);
        check("rst addr", {page_set, row_add_user, col_add_user}, 22'd0);
        check("rst state", fsm_state, 2'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table of pixel pairs
        send(1'b0, 8'h2C);
        check("state after 2C", fsm_state, 2'd2);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, tbl[i].b1);
            send(1'b1, tbl[i].b2);
            check($sformatf("tbl%0d full", i), FIFO_full, 1'b1);
            check($sformatf("tbl%0d word", i), FIFO_out, pick(tbl[i].be, tbl[i].le));
            read_word($sformatf("tbl%0d read", i));
            check($sformatf("tbl%0d drained", i), FIFO_full, 1'b0);
        end

        // Overflow: 9 words into an 8-deep FIFO
        for (int i = 0; i < 18; i++) send(1'b1, 8'($urandom_range(0, 255)));
        check("ovf busy", host_busy, 1'b1);
        check("ovf flag", ovf, exp_ovf);
        check("ovf model", exp_ovf, 1'b1);
        check("ovf count", exp_q.size(), 32'd8);
        send(1'b0, 8'h02);
        check("clr ovf", ovf, 1'b0);
        check("clr keeps busy", host_busy, 1'b1);
        check("clr state", fsm_state, 2'd0);

        // Full FIFO: push and pop in one cycle
        send(1'b0, 8'h2C);
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        send(1'b1, a);
        check("hi state", fsm_state, 2'd3);
        send_with_pop(b);
        check("pushpop busy", host_busy, 1'b1);
        check("pushpop ovf", ovf, 1'b0);
        for (int i = 0; i < D; i++) read_word($sformatf("drain%0d", i));
        check("drain empty", FIFO_full, 1'b0);
        check("drain busy", host_busy, 1'b0);

        // Command aborts a half pixel
        send(1'b0, 8'h2C);
        send(1'b1, 8'hAA);
        send(1'b0, 8'h2C);
        send(1'b1, 8'h12);
        send(1'b1, 8'h34);
        check("abort one word", exp_q.size(), 32'd1);
        check("abort word", FIFO_out, pick(16'h1234, 16'h3412));
        read_word("abort read");
        check("abort empty", FIFO_full, 1'b0);

        // Reset mid-stream
        send(1'b1, 8'h11);
        send(1'b1, 8'h22);
        send(1'b1, 8'h33);
        inc(7);
        check("pre-rst col", col_add_user, 10'd7);
        pulse_reset();
        check("midrst full", FIFO_full, 1'b0);
        check("midrst addr", {row_add_user, col_add_user}, 19'd0);
        rst = 1'b1;
        send(1'b1, 8'h44);
        check("idle data ignored", FIFO_full, 1'b0);
        send(1'b0, 8'h2C);
        send(1'b1, 8'h44);
        send(1'b1, 8'h55);
        read_word("post-rst read");

        // Page select
        send(1'b0, 8'h01);
        check("page state", fsm_state, 2'd1);
        send(1'b1, 8'hFD);
        check("page set", page_set, 3'd5);
        send(1'b1, 8'h03);
        check("page idle data", page_set, 3'd5);
        check("page no push", FIFO_full, 1'b0);

        // Address raster
        inc(H - 1);
        check("col last", {row_add_user, col_add_user}, {9'd0, 10'(H - 1)});
        inc(1);
        check("col wrap", {row_add_user, col_add_user}, {9'd1, 10'd0});
        inc(V * H - 1 - H);
        check("page last", {row_add_user, col_add_user}, {9'(V - 1), 10'(H - 1)});
        inc(1);
        check("page wrap", {row_add_user, col_add_user}, 19'd0);

        // Clear command beats a same-cycle increment
        inc(5);
        check("pre-clr col", col_add_user, 10'd5);
        @(negedge clk);
        host_wr = 1'b1; host_dc = 1'b0; host_d = 8'h02; startup_inc = 1'b1;
        @(negedge clk);
        host_wr = 1'b0; startup_inc = 1'b0;
        model_byte(1'b0, 8'h02);
        check("clr priority", {row_add_user, col_add_user}, 19'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pix_host_writer.md
PIX_HOST_WRITER -- requirements
Module: pix_host_writer

Interface
REQ-001 SHALL have parameter H_ACT, default 800, active columns per row.
REQ-002 SHALL have parameter V_ACT, default 480, active rows per page.
REQ-003 SHALL have parameter DEPTH, default 8, pixel FIFO depth in words (power of two).
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port host_wr, input, 1, single-cycle byte strobe.
REQ-007 SHALL have port host_dc, input, 1, byte type: 0 = command, 1 = data.
REQ-008 SHALL have port host_d, input, 8, host byte, sampled when host_wr=1.
REQ-009 SHALL have port host_busy, output, 1, FIFO holds DEPTH words.
REQ-010 SHALL have port ovf, output, 1, sticky FIFO-overflow flag.
REQ-011 SHALL have port FIFO_out, output, 16, FIFO head word in RGB565 (show-ahead).
REQ-012 SHALL have port FIFO_full, output, 1, at least one word is available to read.
REQ-013 SHALL have port FIFO_RD_req, input, 1, pops the head word for one cycle.
REQ-014 SHALL have port startup_inc, input, 1, advances the pixel address by one.
REQ-015 SHALL have port row_add_user, output, 9, write row address.
REQ-016 SHALL have port col_add_user, output, 10, write column address.
REQ-017 SHALL have port page_set, output, 3, write page select.

Function
REQ-018 SHALL implement an FSM with states IDLE, PAGE_ARG, PIX_HI and PIX_LO.
REQ-019 SHALL act on each command byte (host_wr=1, host_dc=0) in any state, discarding any held high byte: 0x01 goes to PAGE_ARG; 0x02 clears row/col to 0, clears ovf and goes to IDLE; 0x2C goes to PIX_HI; any other value goes to IDLE.
REQ-020 SHALL, on a data byte in PAGE_ARG, load page_set with host_d[2:0] and go to IDLE.
REQ-021 SHALL ignore data bytes in IDLE.
REQ-022 SHALL, on a data byte in PIX_HI, latch the high byte and go to PIX_LO.
REQ-023 SHALL, on a data byte in PIX_LO, push {high, low} and go to PIX_HI (streaming continues).
REQ-024 SHALL make a pushed word visible on FIFO_out, with FIFO_full=1, on the cycle after the push when the FIFO was empty.
REQ-025 SHALL, on FIFO_RD_req with FIFO_full=1, pop the head word so that FIFO_out shows the next word on the following cycle.
REQ-026 SHALL ignore FIFO_RD_req when the FIFO is empty.
REQ-027 SHALL perform both a push and a pop in the same cycle, with count unchanged, including when the FIFO is full.
REQ-028 SHALL, on a push while full without a pop, drop the word and set ovf (sticky).
REQ-029 SHALL, on each startup_inc pulse, increment col_add_user; at H_ACT-1 it wraps to 0 and row_add_user increments; at V_ACT-1 the row wraps to 0.
REQ-030 SHALL give command 0x02 priority over a startup_inc in the same cycle.
REQ-031 SHALL keep the address independent of FIFO activity.

Reset
REQ-032 SHALL, while rst=0, place the FSM in IDLE; clear the FIFO, row, col and page_set to 0; and drive FIFO_full=0, host_busy=0, ovf=0 and FIFO_out=0x0000.
REQ-033 SHALL, on reset mid-pixel, lose the held byte and all FIFO contents.

Configuration
REQ-034 SHALL, with PIX_LE_EN defined, take the low byte first, so PIX_HI latches the low byte and the pushed word is {second, first}.
REQ-035 SHALL, without PIX_LE_EN, take the high byte first, as in REQ-022/023.

Verification
REQ-036 SHALL cover: cmd 0x2C, then data 0xF8, 0x1F -> FIFO_out=0xF81F with FIFO_full=1 one cycle later (0x1FF8 with PIX_LE_EN).
REQ-037 SHALL cover: cmd 0x2C, then 18 data bytes with no reads -> 8 words held, host_busy=1, ovf=1; cmd 0x02 -> ovf=0 and the FIFO keeps its 8 words.
REQ-038 SHALL cover: 799 startup_inc pulses -> col=799, row=0; one more pulse -> col=0, row=1; at row=479, col=799, one pulse -> 0/0.
REQ-039 SHALL cover: cmd 0x01, data 0xFD -> page_set=5; a data byte in IDLE -> no change.
REQ-040 SHALL cover: FIFO full, with push and FIFO_RD_req in the same cycle -> count stays 8, ovf=0, and word order is preserved.
REQ-041 SHALL cover: cmd 0x2C, data 0xAA, cmd 0x2C, data 0x12, 0x34 -> only 0x1234 is pushed; rst pulse mid-stream -> FIFO_full=0 and address 0/0.
